c_selector_sync: RTL and testbench

Clocked, parametrised conditional fork for the control path. On each accepted drive request it samples an N-bit valid vector and fires a drive pulse to every selected downstream channel after a fixed settle delay. It then collects free pulses from the driven channels, either the first one or all of them, and returns a single free pulse upstream. It replaces the fixed 4-way click selector wherever the control path runs on the system clock, and adds channel-count, delay, join-mode and one-hot-select generality.

---
 rtl/c_selector_sync.sv | 130 +++++++++++++
 tb/tb_c_selector_sync.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_selector_sync.sv
// Clocked conditional fork: accepts a drive request, pulses the selected channels
// after a settle delay, then joins their free pulses (first-of or all-of) into one upstream free.
module c_selector_sync #(
  parameter int unsigned N           = 4,
  parameter int unsigned DRIVE_DELAY = 8,
  parameter bit          JOIN_ALL    = 1'b0,
  parameter bit          ONEHOT      = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_drive,
  input  logic [N-1:0] valid,
  output logic         o_fire,
  output logic [N-1:0] o_driveNext,
  input  logic [N-1:0] i_freeNext,
  output logic         o_free,
  output logic         o_busy,
  output logic         o_drop
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   counter, counter_d;
  logic [N-1:0]       sel, sel_d;
  logic [N-1:0]       pending, pending_d;
  logic [N-1:0]       pick;
  logic [N-1:0]       remaining;
  logic               fire_d, free_d, drop_d, busy_d;
  logic [N-1:0]       drive_d;
  logic               complete;

  // Channel select captured at accept; one-hot mode isolates the lowest set bit.
  always_comb begin
    pick = valid;
    if (ONEHOT) pick = valid & (~valid + N'(1));
  end

  // Join condition evaluated against this cycle's frees.
  always_comb begin
    remaining = pending & ~i_freeNext;
    if (JOIN_ALL) complete = (remaining == '0);
    else          complete = (|(sel & i_freeNext)) || (sel == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      sel         <= '0;
      pending     <= '0;
      o_fire      <= 1'b0;
      o_driveNext <= '0;
      o_free      <= 1'b0;
      o_busy      <= 1'b0;
      o_drop      <= 1'b0;
    end else begin
      state       <= state_d;
      counter     <= counter_d;
      sel         <= sel_d;
      pending     <= pending_d;
      o_fire      <= fire_d;
      o_driveNext <= drive_d;
      o_free      <= free_d;
      o_busy      <= busy_d;
      o_drop      <= drop_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state;
    counter_d = counter;
    sel_d     = sel;
    pending_d = pending;
    fire_d    = 1'b0;
    drive_d   = '0;
    free_d    = 1'b0;
    drop_d    = i_drive && (state != IDLE);

    case (state)
      IDLE: begin
        if (i_drive) begin
          sel_d  = pick;
          fire_d = 1'b1;
          if (DRIVE_DELAY == 0) begin
            drive_d   = pick;
            pending_d = pick;
            state_d   = WAIT;
          end else begin
            counter_d = CNT_W'(DRIVE_DELAY);
            state_d   = DELAY;
          end
        end
      end
      DELAY: begin
        if (counter == CNT_W'(1)) begin
          counter_d = '0;
          drive_d   = sel;
          pending_d = sel;
          state_d   = WAIT;
        end else begin
          counter_d = counter - CNT_W'(1);
        end
      end
      WAIT: begin
        pending_d = remaining;
        if (complete) begin
          free_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        pending_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_c_selector_sync.sv
// Scoreboard bench for c_selector_sync: three parameter sets, expected output
// events queued at stimulus time and compared every cycle against the DUT.
`timescale 1ns/1ps
module tb_c_selector_sync;

  localparam int K_FIRE  = 0;
  localparam int K_DRIVE = 1;
  localparam int K_FREE  = 2;
  localparam int K_DROP  = 3;
  localparam int BIG     = 1 << 30;

  typedef struct {
    int         inst;
    int         kind;
    int         cyc;
    logic [3:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       drv    [3];
  logic [3:0] vld    [3];
  logic [3:0] fre    [3];
  logic       fire_o [3];
  logic [3:0] drvn_o [3];
  logic       free_o [3];
  logic       busy_o [3];
  logic       drop_o [3];

  int dly    [3] = '{8, 0, 3};
  bit join_m [3] = '{1'b0, 1'b1, 1'b0};
  bit oh_m   [3] = '{1'b0, 1'b0, 1'b1};

  ev_t        sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         busy_lo [3] = '{1, 1, 1};
  int         busy_hi [3] = '{0, 0, 0};
  int         drive_cyc [3];
  logic [3:0] sel_e [3];
  logic [3:0] pend [3];
  logic [3:0] last_valid [3] = '{4'h0, 4'h0, 4'h0};
  bit         active [3] = '{1'b0, 1'b0, 1'b0};
  int         n_fire [3] = '{0, 0, 0};
  int         n_free [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  c_selector_sync #(.N(4), .DRIVE_DELAY(8), .JOIN_ALL(1'b0), .ONEHOT(1'b0)) u_or (
    .clk(clk), .rst(rst), .i_drive(drv[0]), .valid(vld[0]), .o_fire(fire_o[0]),
    .o_driveNext(drvn_o[0]), .i_freeNext(fre[0]), .o_free(free_o[0]),
    .o_busy(busy_o[0]), .o_drop(drop_o[0]));

  c_selector_sync #(.N(4), .DRIVE_DELAY(0), .JOIN_ALL(1'b1), .ONEHOT(1'b0)) u_and (
    .clk(clk), .rst(rst), .i_drive(drv[1]), .valid(vld[1]), .o_fire(fire_o[1]),
    .o_driveNext(drvn_o[1]), .i_freeNext(fre[1]), .o_free(free_o[1]),
    .o_busy(busy_o[1]), .o_drop(drop_o[1]));

  c_selector_sync #(.N(4), .DRIVE_DELAY(3), .JOIN_ALL(1'b0), .ONEHOT(1'b1)) u_oh (
    .clk(clk), .rst(rst), .i_drive(drv[2]), .valid(vld[2]), .o_fire(fire_o[2]),
    .o_driveNext(drvn_o[2]), .i_freeNext(fre[2]), .o_free(free_o[2]),
    .o_busy(busy_o[2]), .o_drop(drop_o[2]));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] lowbit(logic [3:0] v);
    logic [3:0] r = '0;
    for (int b = 3; b >= 0; b--) if (v[b]) r = 4'(1 << b);
    return r;
  endfunction

  function automatic logic [3:0] collect(int i, int k);
    logic [3:0] r = '0;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].inst == i && sb[j].kind == k && sb[j].cyc == cyc) begin
        r |= sb[j].val;
        sb.delete(j);
      end
    end
    return r;
  endfunction

  task automatic push(int i, int k, int c, logic [3:0] v);
    ev_t e;
    e.inst = i; e.kind = k; e.cyc = c; e.val = v;
    sb.push_back(e);
  endtask

  // Per-cycle comparison of every output of every instance.
  always @(posedge clk) begin
    logic rst_edge;
    rst_edge = rst;
    cyc++;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fire%0d", i),  32'(fire_o[i]), 32'(collect(i, K_FIRE)));
      check($sformatf("drive%0d", i), 32'(drvn_o[i]), 32'(collect(i, K_DRIVE)));
      check($sformatf("free%0d", i),  32'(free_o[i]), 32'(collect(i, K_FREE)));
      check($sformatf("drop%0d", i),  32'(drop_o[i]), 32'(collect(i, K_DROP)));
      check($sformatf("busy%0d", i),  32'(busy_o[i]),
            32'(cyc >= busy_lo[i] && cyc <= busy_hi[i]));
      check($sformatf("drive_in_valid%0d", i), 32'(drvn_o[i] & ~last_valid[i]), 32'd0);
      n_fire[i] += int'(fire_o[i] === 1'b1);
      n_free[i] += int'(free_o[i] === 1'b1);
      check($sformatf("outstanding%0d", i), 32'((n_fire[i] - n_free[i]) > 1), 32'd0);
      if (rst_edge) n_fire[i] = n_free[i];
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drv[i] = 1'b0;
      fre[i] = '0;
    end
  endtask

  task automatic wait_until(int t);
    while (cyc < t) next_cycle();
  endtask

  task automatic finish_wait(int i);
    int g = 0;
    while (cyc <= busy_hi[i] && g < 300) begin
      next_cycle();
      g++;
    end
  endtask

  task automatic start(int i, logic [3:0] v);
    logic [3:0] s;
    int a;
    a = cyc;
    s = oh_m[i] ? lowbit(v) : v;
    push(i, K_FIRE, a + 1, 4'd1);
    drive_cyc[i]  = a + 1 + dly[i];
    if (s != '0) push(i, K_DRIVE, drive_cyc[i], s);
    sel_e[i]      = s;
    pend[i]       = s;
    last_valid[i] = v;
    busy_lo[i]    = a + 1;
    busy_hi[i]    = BIG;
    active[i]     = 1'b1;
    if (s == '0) begin
      push(i, K_FREE, drive_cyc[i] + 1, 4'd1);
      busy_hi[i] = drive_cyc[i] + 1;
      active[i]  = 1'b0;
    end
  endtask

  task automatic req(int i, logic [3:0] v);
    drv[i] = 1'b1;
    vld[i] = v;
    if (cyc >= busy_lo[i] && cyc <= busy_hi[i]) push(i, K_DROP, cyc + 1, 4'd1);
    else start(i, v);
  endtask

  task automatic give_free(int i, logic [3:0] f);
    bit done;
    fre[i] = f;
    if (active[i] && cyc >= drive_cyc[i]) begin
      pend[i] &= ~f;
      done = join_m[i] ? (pend[i] == '0) : (|(sel_e[i] & f));
      if (done) begin
        push(i, K_FREE, cyc + 1, 4'd1);
        busy_hi[i] = cyc + 1;
        active[i]  = 1'b0;
      end
    end
  endtask

  // Synchronous reset for one cycle: drops every queued future event.
  task automatic pulse_reset();
    rst = 1'b1;
    for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].cyc > cyc) sb.delete(j);
    for (int i = 0; i < 3; i++) begin
      if (busy_hi[i] > cyc) busy_hi[i] = cyc;
      active[i] = 1'b0;
    end
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int a;
    int bits[$];
    logic [3:0] v, f;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv[i] = 1'b0; vld[i] = '0; fre[i] = '0;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        drv[i] = 1'($urandom_range(0, 1));
        vld[i] = 4'($urandom_range(0, 15));
        fre[i] = 4'($urandom_range(0, 15));
      end
    end
    next_cycle();
    rst = 1'b0;
    repeat (2) next_cycle();

    // Multicast OR join with drops in DELAY, WAIT and the free cycle.
    a = cyc;
    req(0, 4'b1010);
    wait_until(a + 3);  req(0, 4'b0001);
    wait_until(a + 10); req(0, 4'b0100);
    wait_until(a + 12); give_free(0, 4'b0010);
    wait_until(a + 13); req(0, 4'b1111);
    wait_until(a + 15); give_free(0, 4'b1000);
    wait_until(a + 18);

    // AND join with a stray free on an unselected channel.
    a = cyc;
    req(1, 4'b0111);
    wait_until(a + 3); give_free(1, 4'b0001);
    wait_until(a + 5); give_free(1, 4'b1100);
    wait_until(a + 7); give_free(1, 4'b0010);
    wait_until(a + 10);

    // Minimum turnaround: free in drive cycle, drop in free cycle, accept next.
    a = cyc;
    req(1, 4'b0011);
    next_cycle(); give_free(1, 4'b0011);
    next_cycle(); req(1, 4'b0001);
    next_cycle(); req(1, 4'b0001);
    give_free(1, 4'b0001);
    finish_wait(1);

    // One-hot select, then empty select, then another one-hot pattern.
    req(2, 4'b1100);
    wait_until(drive_cyc[2]); give_free(2, 4'b1000);
    next_cycle(); give_free(2, 4'b0100);
    finish_wait(2);
    req(2, 4'b0000);
    finish_wait(2);
    req(2, 4'b0110);
    wait_until(drive_cyc[2]); give_free(2, 4'b0010);
    finish_wait(2);

    // Abort mid-DELAY, then a normal transaction.
    a = cyc;
    req(0, 4'b1111);
    wait_until(a + 4);
    pulse_reset();
    wait_until(a + 12);
    req(0, 4'b0101);
    wait_until(drive_cyc[0] + 1); give_free(0, 4'b0100);
    finish_wait(0);
    next_cycle();

    // Random back-to-back transactions on both join modes.
    for (int t = 0; t < 100; t++) begin
      int i;
      i = t % 2;
      repeat ($urandom_range(0, 2)) next_cycle();
      next_cycle();
      v = 4'($urandom_range(0, 15));
      a = cyc;
      req(i, v);
      if (dly[i] > 0 && $urandom_range(0, 3) == 0) begin
        next_cycle(); give_free(i, 4'b1111);
      end
      wait_until(drive_cyc[i]);
      repeat ($urandom_range(0, 2)) next_cycle();
      bits.delete();
      for (int b = 0; b < 4; b++) if (sel_e[i][b]) bits.push_back(b);
      for (int k = bits.size() - 1; k > 0; k--) begin
        int j, tmp;
        j = $urandom_range(0, k);
        tmp = bits[k]; bits[k] = bits[j]; bits[j] = tmp;
      end
      foreach (bits[k]) begin
        f = 4'(1 << bits[k]);
        if ($urandom_range(0, 3) == 0) f |= 4'($urandom_range(0, 15)) & ~sel_e[i];
        give_free(i, f);
        repeat ($urandom_range(1, 3)) next_cycle();
      end
      finish_wait(i);
    end
    repeat (4) next_cycle();

    for (int i = 0; i < 3; i++)
      check($sformatf("fire_eq_free%0d", i), 32'(n_fire[i]), 32'(n_free[i]));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
